seq_pattern_tx: RTL
===================

# seq_pattern_tx

Serial pattern transmitter that drives the single-bit `x` input of our sequence detectors, such as the 0110 Mealy detector. On a `start` request it captures a PAT_W-bit pattern and a repetition count. It then shifts the pattern out MSB-first, one bit per clock, optionally inserting idle gaps between repetitions, and pulses `done` on completion. It serves as the stimulus/source end of the detector link in both benches and integrated datapaths.

## Interface
- PAT_W, 4: pattern width in bits (≥2).
- CNT_W, 4: width of the repetition counter.
- GAP_CYC, 0: idle cycles inserted between consecutive repetitions (0 = back-to-back).
- IDLE_BIT, 1'b1: level driven on `x_out` whenever no pattern bit is being sent.

- clk  in  1  clock, all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clock clk.
- start  in  1  request; sampled only in IDLE.
- pattern  in  PAT_W  bits to send; bit PAT_W-1 goes first; captured on accepted start.
- repeat_cnt  in  CNT_W  number of repetitions; 0 = continuous until abort; captured on accepted start.
- abort  in  1  terminate transmission; sampled in SEND and GAP.
- x_out  out  1  serial data, registered.
- valid  out  1  high while `x_out` carries a pattern bit.
- busy  out  1  high in SEND and GAP.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  qualifies `done`: 1 if the run ended by abort; held until the next accepted start.

## Operation
- States: IDLE, SEND, GAP, FIN. Encoding is free. All outputs are registered.
- Reset (async, any state): state=IDLE, x_out=IDLE_BIT, valid=0, busy=0, done=0, aborted=0, bit index=0, rep counter=0.
- IDLE: x_out=IDLE_BIT.
  - start=1 → latch pattern into the shift register and repeat_cnt into the rep counter, clear `aborted`, go to SEND with index 0.
- SEND: x_out=shift_reg[PAT_W-1-index], valid=1, busy=1. Index increments each cycle.
  - On the last bit (index=PAT_W-1):
    - Continuous mode (latched count 0): always another repetition.
    - Otherwise decrement the rep counter. If it reaches 0 → FIN; else another repetition.
  - Another repetition goes to GAP if GAP_CYC>0, else stays in SEND with index 0 (no bubble).
- GAP: x_out=IDLE_BIT, valid=0, busy=1 for exactly GAP_CYC cycles, then SEND with index 0.
- FIN: x_out=IDLE_BIT, valid=0, busy=0, done=1 for one cycle, then IDLE. start in FIN is ignored.
- abort=1 in SEND or GAP → FIN on the next edge with aborted=1. A partial pattern is truncated, not completed. abort has priority over a normal end on the same edge. abort is ignored in IDLE and FIN.
- start while busy or in FIN is ignored. Changes to pattern/repeat_cnt after capture have no effect.
- The rep counter is CNT_W bits and never wraps. The decrement happens only when the latched count is non-zero.

## Timing
- start sampled high at edge t0 (IDLE): first bit on x_out from edge t0 through edge t0+1. Bit i is driven after edge t0+i.
- Finite run with R repetitions and gap G: last bit after edge t0+R·PAT_W+(R-1)·G-1. done=1 after the following edge for exactly 1 cycle. IDLE is reached one edge later. The earliest next accepted start is at that IDLE edge.
- abort sampled at edge ta: done and aborted are high after edge ta. x_out returns to IDLE_BIT at the same edge.
- valid and x_out change on the same edge. Consumers sample on the next rising edge.
- Reset mid-transmission: outputs reach reset values immediately, with no done pulse.

## Test plan
- Defaults; pattern=4'b0110, repeat_cnt=2, GAP_CYC=0 → x_out 0,1,1,0,0,1,1,0 with valid=1 for 8 cycles; done pulse 1 cycle later with aborted=0; a downstream 0110 detector's z asserts on the last bit of each repetition (2 pulses).
- GAP_CYC=2, pattern=4'b1010, repeat_cnt=2 → 1,0,1,0,IDLE,IDLE,1,0,1,0; valid low exactly during the 2 gap cycles; done after the 10th output cycle.
- repeat_cnt=0, pattern=4'b0110, abort asserted on the 3rd bit of the 3rd repetition → 2 full patterns plus "01"; the next cycle has done=1, aborted=1, x_out=1.
- start pulsed again mid-run with pattern=4'b1111 → ignored, the original stream is unchanged; start in the FIN cycle is also ignored; start in the following IDLE cycle is accepted.
- Async reset asserted mid-SEND (between clock edges) → x_out=1, valid=busy=done=0 immediately; no done after release; a new start works normally.
- repeat_cnt=1 with an abort on the same edge as the last bit → done with aborted=1 (abort priority).

Source files
------------

// File: rtl/seq_pattern_tx.sv
// Serial pattern source: shifts a captured PAT_W-bit pattern out MSB-first,
// repeating it a latched number of times (0 = until abort) with optional idle gaps.
module seq_pattern_tx #(
   parameter int unsigned PAT_W    = 4,
   parameter int unsigned CNT_W    = 4,
   parameter int unsigned GAP_CYC  = 0,
   parameter logic        IDLE_BIT = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] repeat_cnt,
   input  logic             abort,
   output logic             x_out,
   output logic             valid,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_GAP  = 2'd2,
      S_FIN  = 2'd3
   } state_t;

   localparam int unsigned    IW       = $clog2(PAT_W);
   localparam int unsigned    GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [IW-1:0]  IDX_LAST = IW'(PAT_W - 1);
   localparam logic [GW-1:0]  GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

   state_t           state_q;
   logic [PAT_W-1:0] shreg_q;
   logic [IW-1:0]    idx_q;
   logic [CNT_W-1:0] rep_q;
   logic             cont_q;
   logic [GW-1:0]    gap_q;

   assign state_dbg = state_q;

   // The shift register rotates once per sent bit, so x_out always takes the
   // bit just below the MSB; after PAT_W rotations it holds the original pattern
   // again, which makes back-to-back repetitions and gap exits seamless.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         shreg_q <= '0;
         idx_q   <= '0;
         rep_q   <= '0;
         cont_q  <= 1'b0;
         gap_q   <= '0;
         x_out   <= IDLE_BIT;
         valid   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         aborted <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            S_IDLE: begin
               x_out <= IDLE_BIT;
               valid <= 1'b0;
               busy  <= 1'b0;
               if (start) begin
                  state_q <= S_SEND;
                  shreg_q <= pattern;
                  rep_q   <= repeat_cnt;
                  cont_q  <= (repeat_cnt == '0);
                  idx_q   <= '0;
                  aborted <= 1'b0;
                  x_out   <= pattern[PAT_W-1];
                  valid   <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            S_SEND: begin
               if (abort) begin
                  state_q <= S_FIN;
                  x_out   <= IDLE_BIT;
                  valid   <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  aborted <= 1'b1;
               end else begin
                  shreg_q <= {shreg_q[PAT_W-2:0], shreg_q[PAT_W-1]};
                  if (idx_q == IDX_LAST) begin
                     idx_q <= '0;
                     if (!cont_q) rep_q <= rep_q - CNT_W'(1);
                     if (!cont_q && (rep_q == CNT_W'(1))) begin
                        state_q <= S_FIN;
                        x_out   <= IDLE_BIT;
                        valid   <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                     end else if (GAP_CYC > 0) begin
                        state_q <= S_GAP;
                        gap_q   <= '0;
                        x_out   <= IDLE_BIT;
                        valid   <= 1'b0;
                     end else begin
                        x_out <= shreg_q[PAT_W-2];
                     end
                  end else begin
                     idx_q <= idx_q + IW'(1);
                     x_out <= shreg_q[PAT_W-2];
                  end
               end
            end
            S_GAP: begin
               if (abort) begin
                  state_q <= S_FIN;
                  x_out   <= IDLE_BIT;
                  valid   <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  aborted <= 1'b1;
               end else if (gap_q == GAP_LAST) begin
                  state_q <= S_SEND;
                  idx_q   <= '0;
                  x_out   <= shreg_q[PAT_W-1];
                  valid   <= 1'b1;
               end else begin
                  gap_q <= gap_q + GW'(1);
               end
            end
            S_FIN: begin
               state_q <= S_IDLE;
               x_out   <= IDLE_BIT;
               valid   <= 1'b0;
               busy    <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
